// File: rtl/memory_frame_reader.sv
// rtl/memory_frame_reader.sv - snapshots an M-word frame on start and streams it out word by word over valid/ready
module memory_frame_reader #(
    parameter int M = 5,
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [M*N-1:0]       frame_in,
    output logic [N-1:0]         out_data,
    output logic [$clog2(M)-1:0] out_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int AW = $clog2(M);
    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [M*N-1:0]   snapshot, snapshot_n;
    logic [N-1:0]     data_n;
    logic [AW-1:0]    addr_n, addr_inc;
    logic             valid_n, last_n, busy_n, done_n;

    // out_addr doubles as the read index; all stream outputs are registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            snapshot  <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            snapshot  <= snapshot_n;
            out_data  <= data_n;
            out_addr  <= addr_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        snapshot_n = snapshot;
        data_n     = out_data;
        addr_n     = out_addr;
        valid_n    = out_valid;
        last_n     = out_last;
        busy_n     = busy;
        done_n     = 1'b0;
        addr_inc   = out_addr + 1'b1;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n    = S_STREAM;
                    snapshot_n = frame_in;
                    data_n     = frame_in[N-1:0];
                    addr_n     = '0;
                    valid_n    = 1'b1;
                    last_n     = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            S_STREAM: begin
                // Outputs only move on an accepted beat, so a stall holds them stable
                if (out_valid && out_ready) begin
                    if (out_addr == LAST_ADDR) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        addr_n = addr_inc;
                        data_n = snapshot[int'(addr_inc)*N +: N];
                        last_n = (addr_inc == LAST_ADDR);
                    end
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_frame_reader.sv
// tb/tb_memory_frame_reader.sv - randomized scoreboard bench for memory_frame_reader
module tb_memory_frame_reader;

    localparam int M  = 5;
    localparam int N  = 8;
    localparam int AW = $clog2(M);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           out_ready = 1'b0;
    logic [M*N-1:0] frame_in = '0;
    logic [N-1:0]   out_data;
    logic [AW-1:0]  out_addr;
    logic           out_valid, out_last, busy, done;

    memory_frame_reader #(.M(M), .N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_in(frame_in),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  data;
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    beat_t q[$];
    int    phase = 0;       // 0 idle, 1 streaming, 2 done cycle
    int    beats_left = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a start in idle queues all M words; each ready cycle consumes one
    task automatic model_step();
        beat_t b;
        case (phase)
            0: if (start) begin
                for (int k = 0; k < M; k++) begin
                    b.data = frame_in[k*N +: N];
                    b.addr = AW'(k);
                    b.last = (k == M - 1);
                    q.push_back(b);
                end
                beats_left = M;
                phase = 1;
            end
            1: if (out_ready) begin
                beats_left--;
                if (beats_left == 0) phase = 2;
            end
            default: phase = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic set_frame(input logic [N-1:0] base);
        for (int k = 0; k < M; k++) frame_in[k*N +: N] = base + N'(k);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < M; k++) frame_in[k*N +: N] = N'($urandom);
    endtask

    task automatic mid_reset();
        reset = 1'b1;
        start = 1'b0;
        q.delete();
        phase = 0;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("valid", 32'(out_valid), 32'(phase == 1));
            check("busy", 32'(busy), 32'(phase != 0));
            check("done", 32'(done), 32'(phase == 2));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("beat_expected", 32'd0, 32'd1);
                end else begin
                    check("data", 32'(out_data), 32'(q[0].data));
                    check("addr", 32'(out_addr), 32'(q[0].addr));
                    check("last", 32'(out_last), 32'(q[0].last));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_addr", 32'(out_addr), 32'd0);
        check("init_data", 32'(out_data), 32'd0);
        check("init_last", 32'(out_last), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Full-rate frame E0..E4
        set_frame(8'hE0);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();

        // Stalled frame with ready pattern 1,0,0
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            out_ready = (i % 3 == 0);
            tick();
        end
        out_ready = 1'b1;
        repeat (3) tick();

        // Frame overwritten right after start
        set_frame(8'hA0);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_frame(8'hB0);
        repeat (8) tick();

        // Reset during the fourth beat, then a fresh frame
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        mid_reset();
        set_frame(8'h50);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();

        // Start held high: ignored mid-frame and in DONE, back-to-back frames
        set_frame(8'hC0);
        start = 1'b1;
        repeat (16) tick();
        start = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom % 3 == 0);
            out_ready = ($urandom % 4 != 0);
            rand_frame();
            if (phase == 1 && $urandom % 150 == 0) mid_reset();
            else tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
